// File: rtl/seg_display_pkg.sv
// seg_display_pkg: shared types and constants for the BCD display scanner.
//   bcd_t              4-bit BCD digit
//   BCD_MAX            largest legal BCD value (9)
//   scan_state_t       scanner FSM states {IDLE, SCAN}
//   DEFAULT_NUM_DIGITS default digit count
//   bcd_clean()        maps a non-BCD nibble to 0
package seg_display_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    localparam int DEFAULT_NUM_DIGITS = 4;

    function automatic bcd_t bcd_clean(input bcd_t d);
        return (d > BCD_MAX) ? bcd_t'(4'd0) : d;
    endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// bcd_display_scanner_if: digit-set load channel.
//   load_valid   master offers a digit set
//   load_ready   slave can take a digit set
//   load_digits  4*NUM_DIGITS BCD nibbles, nibble 0 least significant
// Handshake: a transfer happens on a rising clk edge where load_valid and
// load_ready are both high; the master holds load_digits stable while
// load_valid is high, and load_ready never depends on load_valid.
interface bcd_display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_digits;

    modport master (output load_valid, output load_digits, input load_ready);
    modport slave  (input load_valid, input load_digits, output load_ready);
endinterface

// File: rtl/refresh_prescaler.sv
// refresh_prescaler: emits a single-cycle tick every DIV clocks while run
// is high; the count is held at zero whenever run is low.
//   clk, rst_n  clock, asynchronous active-low reset
//   run         count enable (scanner is scanning)
//   tick        high in the last cycle of each DIV-cycle slot
module refresh_prescaler #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = run && (cnt_q == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!run || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: time-multiplexes NUM_DIGITS BCD digits onto one
// seven-segment decoder input (w,x,y,z) with active-low digit enables.
//   clk, rst_n         clock, asynchronous active-low reset
//   enable             scan enable (IDLE <-> SCAN)
//   load_valid/ready   digit-set handshake, load_digits = nibbles
//   w,x,y,z            current digit (w = MSB)
//   digit_en_n         active-low digit enables
//   digit_idx          digit currently driven
//   invalid_err        sticky: a non-BCD nibble was accepted (replaced by 0)
//   dbg_state          FSM state for observation
// Optional build macro LEADING_ZERO_BLANK_EN: blank leading zero digits
// (digit 0 is always shown).
module bcd_display_scanner
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [4*NUM_DIGITS-1:0]       load_digits,
    output logic                          w,
    output logic                          x,
    output logic                          y,
    output logic                          z,
    output logic [NUM_DIGITS-1:0]         digit_en_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          invalid_err,
    output scan_state_t                   dbg_state
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [IDX_W-1:0]        idx_q;
    logic [4*NUM_DIGITS-1:0] active_q, shadow_q, load_clean;
    logic                    pending_q, rdy_q, err_q, load_bad;
    logic                    run, tick, wrap, accept;
    logic [NUM_DIGITS-1:0]   blank;
    bcd_t                    cur;

    // Slot counter only runs while we stay in SCAN, so it reads 0 in IDLE
    // and restarts from 0 on every IDLE->SCAN entry.
    assign run    = (state_q == ST_SCAN) && enable;
    assign wrap   = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign accept = load_valid && load_ready;

    // rdy_q keeps load_ready low during reset and rises on the first edge.
    assign load_ready  = rdy_q && !pending_q;
    assign digit_idx   = idx_q;
    assign invalid_err = err_q;
    assign dbg_state   = scan_state_t'(state_q);

    refresh_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .tick  (tick)
    );

    always_comb begin
        load_clean = '0;
        load_bad   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            load_clean[4*i +: 4] = bcd_clean(load_digits[4*i +: 4]);
            if (load_digits[4*i +: 4] > BCD_MAX) load_bad = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable)  state_d = ST_SCAN;
            default: if (!enable) state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (!run)      idx_q <= '0;
            else if (wrap) idx_q <= '0;
            else if (tick) idx_q <= idx_q + 1'b1;
        end
    end

    // Loads go straight to active when idle; while scanning they wait in
    // the shadow until the frame boundary so no frame mixes two sets.
    // A load accepted in the wrap cycle has pending_q still low there, so
    // it naturally waits for the following wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (accept && load_bad) err_q <= 1'b1;
            if (state_q == ST_IDLE) begin
                if (accept) active_q <= load_clean;
            end else if (!enable) begin
                // Leaving SCAN: nothing may stay parked in the shadow.
                if (accept)         active_q <= load_clean;
                else if (pending_q) active_q <= shadow_q;
                pending_q <= 1'b0;
            end else if (accept) begin
                shadow_q  <= load_clean;
                pending_q <= 1'b1;
            end else if (pending_q && wrap) begin
                active_q  <= shadow_q;
                pending_q <= 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic leading;
    always_comb begin
        blank   = '0;
        leading = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (leading && (active_q[4*i +: 4] == 4'd0)) blank[i] = 1'b1;
            else                                         leading  = 1'b0;
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        cur = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) cur = active_q[4*i +: 4];
        end
        {w, x, y, z} = 4'b0000;
        digit_en_n   = '1;
        if (state_q == ST_SCAN) begin
            {w, x, y, z} = cur;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if ((idx_q == IDX_W'(i)) && !blank[i]) digit_en_n[i] = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed bench for bcd_display_scanner with
// NUM_DIGITS=4, REFRESH_DIV=4. Build with LEADING_ZERO_BLANK_EN defined to
// check the blanking variant.
module tb_bcd_display_scanner;
    import seg_display_pkg::*;

    localparam int ND = 4;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        w, x, y, z;
    logic [3:0]  digit_en_n;
    logic [1:0]  digit_idx;
    logic        invalid_err;
    scan_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    bcd_display_scanner_if #(.NUM_DIGITS(ND)) ld ();

    always #5 clk = ~clk;

    bcd_display_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .load_valid  (ld.load_valid),
        .load_ready  (ld.load_ready),
        .load_digits (ld.load_digits),
        .w           (w),
        .x           (x),
        .y           (y),
        .z           (z),
        .digit_en_n  (digit_en_n),
        .digit_idx   (digit_idx),
        .invalid_err (invalid_err),
        .dbg_state   (dbg_state)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected enables for slot s showing value v: slot s is blank when it
    // is not slot 0 and every nibble from s upward is zero.
    function automatic logic [3:0] exp_en(input logic [15:0] v, input int s);
        logic [3:0] m = ~(4'b0001 << s);
`ifdef LEADING_ZERO_BLANK_EN
        logic blk = (s != 0);
        for (int i = s; i < ND; i++) begin
            if (v[4*i +: 4] != 4'd0) blk = 1'b0;
        end
        if (blk) m = 4'hF;
`endif
        return m;
    endfunction

    // Check cycles start..start+n-1 of a frame (4 cycles per slot).
    task automatic check_cycles(input logic [15:0] v, input int start, input int n, input logic rdy);
        for (int k = start; k < start + n; k++) begin
            int s = k / RD;
            chk("digit_idx", 16'(digit_idx), 16'(s));
            chk("bcd_out", 16'({w, x, y, z}), 16'(v[4*s +: 4]));
            chk("digit_en_n", 16'(digit_en_n), 16'(exp_en(v, s)));
            chk("load_ready", 16'(ld.load_ready), 16'(rdy));
            step();
        end
    endtask

    task automatic check_idle(input logic rdy);
        chk("idle_state", 16'(dbg_state), 16'(IDLE));
        chk("idle_en_n", 16'(digit_en_n), 16'hF);
        chk("idle_idx", 16'(digit_idx), 16'd0);
        chk("idle_ready", 16'(ld.load_ready), 16'(rdy));
    endtask

    initial begin
        ld.load_valid  = 1'b0;
        ld.load_digits = '0;
        enable         = 1'b0;
        rst_n          = 1'b0;
        #3;
        chk("rst_ready", 16'(ld.load_ready), 16'd0);
        chk("rst_en_n", 16'(digit_en_n), 16'hF);
        chk("rst_idx", 16'(digit_idx), 16'd0);
        chk("rst_bcd", 16'({w, x, y, z}), 16'd0);
        chk("rst_err", 16'(invalid_err), 16'd0);
        chk("rst_state", 16'(dbg_state), 16'(IDLE));
        #9;
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 16'(ld.load_ready), 16'd0);
        step();
        chk("ready_after_edge", 16'(ld.load_ready), 16'd1);

        // Idle load then scan one frame of 1234.
        ld.load_valid = 1'b1; ld.load_digits = 16'h1234;
        step();
        ld.load_valid = 1'b0;
        check_idle(1'b1);
        enable = 1'b1;
        step();
        chk("scan_state", 16'(dbg_state), 16'(SCAN));
        check_cycles(16'h1234, 0, 16, 1'b1);

        // Mid-frame load waits for the frame boundary.
        check_cycles(16'h1234, 0, 5, 1'b1);
        ld.load_valid = 1'b1; ld.load_digits = 16'h5678;
        check_cycles(16'h1234, 5, 1, 1'b1);
        ld.load_valid = 1'b0;
        check_cycles(16'h1234, 6, 10, 1'b0);
        check_cycles(16'h5678, 0, 16, 1'b1);

        // Load in the wrap cycle: old digits stay one more full frame.
        check_cycles(16'h5678, 0, 15, 1'b1);
        ld.load_valid = 1'b1; ld.load_digits = 16'h9012;
        check_cycles(16'h5678, 15, 1, 1'b1);
        ld.load_valid = 1'b0;
        check_cycles(16'h5678, 0, 16, 1'b0);
        check_cycles(16'h9012, 0, 16, 1'b1);

        // Disable with a load pending: commit on the way to IDLE.
        check_cycles(16'h9012, 0, 2, 1'b1);
        ld.load_valid = 1'b1; ld.load_digits = 16'h3456;
        check_cycles(16'h9012, 2, 1, 1'b1);
        ld.load_valid = 1'b0;
        check_cycles(16'h9012, 3, 2, 1'b0);
        enable = 1'b0;
        check_cycles(16'h9012, 5, 1, 1'b0);
        check_idle(1'b1);
        chk("idle_bcd", 16'({w, x, y, z}), 16'd0);
        enable = 1'b1;
        step();
        check_cycles(16'h3456, 0, 16, 1'b1);

        // Non-BCD nibble replaced by 0, sticky error.
        enable = 1'b0;
        step();
        ld.load_valid = 1'b1; ld.load_digits = 16'h00A5;
        step();
        ld.load_valid = 1'b0;
        chk("err_set", 16'(invalid_err), 16'd1);
        enable = 1'b1;
        step();
        check_cycles(16'h0005, 0, 16, 1'b1);
        enable = 1'b0;
        step();
        ld.load_valid = 1'b1; ld.load_digits = 16'h1111;
        step();
        ld.load_valid = 1'b0;
        chk("err_held", 16'(invalid_err), 16'd1);

        // Reset mid-scan with a pending shadow: shadow is discarded.
        enable = 1'b1;
        step();
        check_cycles(16'h1111, 0, 3, 1'b1);
        ld.load_valid = 1'b1; ld.load_digits = 16'h8888;
        check_cycles(16'h1111, 3, 1, 1'b1);
        ld.load_valid = 1'b0;
        chk("pending_ready", 16'(ld.load_ready), 16'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_err", 16'(invalid_err), 16'd0);
        chk("rst2_ready", 16'(ld.load_ready), 16'd0);
        chk("rst2_en_n", 16'(digit_en_n), 16'hF);
        chk("rst2_state", 16'(dbg_state), 16'(IDLE));
        #2;
        rst_n = 1'b1;
        step();
        chk("rst2_scan", 16'(dbg_state), 16'(SCAN));
        check_cycles(16'h0000, 0, 16, 1'b1);
        check_cycles(16'h0000, 0, 16, 1'b1);

        // Leading-zero pattern.
        enable = 1'b0;
        step();
        ld.load_valid = 1'b1; ld.load_digits = 16'h0070;
        step();
        ld.load_valid = 1'b0;
        enable = 1'b1;
        step();
        check_cycles(16'h0070, 0, 16, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_display_scanner.md
BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 SHALL have parameter: NUM_DIGITS, 4, digit count (2..8).
REQ-002 SHALL have parameter: REFRESH_DIV, 1000, clk cycles per digit slot (>=2).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: clk  in  1  rising-edge clock.
REQ-005 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port: enable  in  1  scan enable.
REQ-007 SHALL have port: load_valid  in  1  new digit set offered.
REQ-008 SHALL have port: load_ready  out  1  digit set accepted when both valid and ready are high.
REQ-009 SHALL have port: load_digits  in  4*NUM_DIGITS  BCD nibbles; nibble 0 is least significant.
REQ-010 SHALL have port: w, x, y, z  out  1 each  current BCD digit to the seven-segment decoder; w=MSB, z=LSB.
REQ-011 SHALL have port: digit_en_n  out  NUM_DIGITS  active-low digit enables.
REQ-012 SHALL have port: digit_idx  out  $clog2(NUM_DIGITS)  digit currently driven.
REQ-013 SHALL have port: invalid_err  out  1  sticky flag for a non-BCD nibble.

Function
REQ-014 SHALL implement FSM states IDLE and SCAN: IDLE->SCAN when enable=1; SCAN->IDLE the cycle after enable=0.
REQ-015 SHALL, in IDLE, hold digit_en_n all ones, digit_idx 0, refresh counter 0.
REQ-016 SHALL, in SCAN, count 0..REFRESH_DIV-1; at terminal count digit_idx advances modulo NUM_DIGITS.
REQ-017 SHALL drive {w,x,y,z} = active[digit_idx] and digit_en_n[digit_idx]=0 (others 1) in SCAN.
REQ-018 SHALL, in IDLE, copy an accepted load directly to active registers on the next edge; load_ready stays 1.
REQ-019 SHALL, in SCAN, place an accepted load in a shadow register, set pending, drive load_ready=0 while pending.
REQ-020 SHALL commit shadow to active on the edge where digit_idx wraps NUM_DIGITS-1->0 (frame boundary), clearing pending; load_ready=1 next cycle.
REQ-021 SHALL NOT commit a load accepted in the wrap cycle itself at that wrap; it commits at the following wrap.
REQ-022 SHALL commit a pending shadow immediately on the SCAN->IDLE transition.
REQ-023 SHALL replace any accepted nibble >9 with 0 and set invalid_err, held until reset.
REQ-024 SHALL restart at digit 0, count 0 on every IDLE->SCAN transition.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force: state IDLE, active and shadow 0, pending 0, counter 0, digit_idx 0, digit_en_n all ones, w/x/y/z 0, invalid_err 0, load_ready 0.
REQ-026 SHALL drive load_ready=1 from the first clk edge after rst_n deasserts.
REQ-027 SHALL discard any in-flight pending shadow on reset mid-scan.

Configuration
REQ-028 SHALL support macro LEADING_ZERO_BLANK_EN.
REQ-029 SHALL, with LEADING_ZERO_BLANK_EN defined, hold digit_en_n high for zero digits from index NUM_DIGITS-1 downward until the first non-zero digit; digit 0 is never blanked; timing is unchanged.
REQ-030 SHALL, without LEADING_ZERO_BLANK_EN, enable every digit in its slot.

Structure
REQ-031 SHALL place in package seg_display_pkg: bcd_t (4-bit typedef), BCD_MAX=9, scan_state_t enum {IDLE, SCAN}, default NUM_DIGITS.
REQ-032 SHALL use one sub-module, refresh_prescaler, producing a single-cycle slot tick every REFRESH_DIV cycles, cleared when not scanning.

Verification (REFRESH_DIV=4, NUM_DIGITS=4)
REQ-033 SHALL cover: reset then load 0x1234 in IDLE, enable=1 -> digit_idx 0,1,2,3 each 4 cycles; {w,x,y,z}=4,3,2,1; digit_en_n=1110,1101,1011,0111.
REQ-034 SHALL cover: load 0x5678 mid-frame while scanning 0x1234 -> load_ready=0 until wrap; first slot after wrap shows 8; no slot shows a mixed frame.
REQ-035 SHALL cover: load accepted in wrap cycle -> old digits displayed one more full frame.
REQ-036 SHALL cover: load 0x00A5 -> active 0x0005, invalid_err=1 and held until rst_n pulse.
REQ-037 SHALL cover: LEADING_ZERO_BLANK_EN with 0x0070 -> digit_en_n high in slots 3 and 2, low in slots 1 and 0; 0x0000 -> only digit 0 lit.
REQ-038 SHALL cover: enable=0 with a load pending -> IDLE next cycle, digit_en_n=1111, pending committed, load_ready=1.
